// File: rtl/midi_pkg.sv
// Shared MIDI constants, parser state encoding and the decoded event record.
package midi_pkg;

    localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
    localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
    localparam logic [7:0] MIDI_RT_MIN   = 8'hF8;

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        KEY,
        VEL
    } parse_state_e;

    typedef struct packed {
        logic       note_on;
        logic [3:0] channel;
        logic [6:0] key;
        logic [6:0] velocity;
    } midi_event_t;

endpackage

// File: rtl/midi_event_fifo.sv
// First-word-fall-through event FIFO; head visible the cycle after its write.
// A push while full is accepted only when a pop happens in the same cycle.
module midi_event_fifo
    import midi_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  midi_event_t push_dat,
    output logic        full,
    input  logic        pop,
    output midi_event_t pop_dat,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    midi_event_t   mem_q [DEPTH];
    logic [AW:0]   wr_q;
    logic [AW:0]   rd_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (AW+1)'(1);
            if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    // Storage needs no reset: entries are only observed behind the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/midi_event_parser.sv
// MIDI Note On/Off parser with running status; event reaches the FIFO one edge after its velocity byte.
// Consumer stalls buffer up to FIFO_DEPTH events, further events are dropped and counted.
module midi_event_parser
    import midi_pkg::*;
#(
    parameter logic [15:0] CHANNEL_MASK = 16'h0200,
    parameter int          FIFO_DEPTH   = 8,
    parameter bit          NOTE_OFF_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din_valid,
    input  logic [7:0] din,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic       evt_note_on,
    output logic [3:0] evt_channel,
    output logic [6:0] evt_key,
    output logic [6:0] evt_velocity,
    output logic [7:0] drop_count
);

    parse_state_e state_q;
    logic         is_on_q;
    logic [3:0]   chan_q;
    logic [6:0]   key_q;
    midi_event_t  ev_q;
    logic         ev_vld_q;
    logic [7:0]   drop_q;

    logic         byte_vld;
    logic         is_note;
    logic         vel_on;
    logic         fifo_full;
    logic         fifo_empty;
    logic         pop;
    midi_event_t  head;

    // Real-time bytes are invisible to the parser.
    assign byte_vld = din_valid && (din < MIDI_RT_MIN);
    assign is_note  = (din[7:4] == MIDI_NOTE_ON) || (din[7:4] == MIDI_NOTE_OFF);
    assign vel_on   = is_on_q && (din[6:0] != 7'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            is_on_q  <= 1'b0;
            chan_q   <= '0;
            key_q    <= '0;
            ev_q     <= '0;
            ev_vld_q <= 1'b0;
        end else begin
            ev_vld_q <= 1'b0;
            if (byte_vld) begin
                if (din[7]) begin
                    if (din[7:4] == 4'hF) begin
                        state_q <= IDLE;
                    end else begin
                        is_on_q <= (din[7:4] == MIDI_NOTE_ON);
                        chan_q  <= din[3:0];
                        state_q <= (is_note && CHANNEL_MASK[din[3:0]]) ? KEY : SKIP;
                    end
                end else begin
                    case (state_q)
                        KEY: begin
                            key_q   <= din[6:0];
                            state_q <= VEL;
                        end
                        VEL: begin
                            state_q  <= KEY;
                            ev_q     <= '{note_on:  vel_on,
                                          channel:  chan_q,
                                          key:      key_q,
                                          velocity: vel_on ? din[6:0] : 7'd0};
                            ev_vld_q <= vel_on || NOTE_OFF_EN;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign pop = evt_valid && evt_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (ev_vld_q && fifo_full && !pop && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    midi_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (ev_vld_q),
        .push_dat (ev_q),
        .full     (fifo_full),
        .pop      (pop),
        .pop_dat  (head),
        .empty    (fifo_empty)
    );

    assign evt_valid    = !fifo_empty;
    assign evt_note_on  = evt_valid ? head.note_on  : 1'b0;
    assign evt_channel  = evt_valid ? head.channel  : 4'd0;
    assign evt_key      = evt_valid ? head.key      : 7'd0;
    assign evt_velocity = evt_valid ? head.velocity : 7'd0;
    assign drop_count   = drop_q;

endmodule

// File: tb/tb_midi_event_parser.sv
// Directed bench: default-parameter parser plus a channel-1, depth-4, no-Note-Off variant.
module tb_midi_event_parser;
    import midi_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din_valid, din_valid2;
    logic [7:0] din, din2;
    logic       evt_ready, evt_ready2;
    logic       evt_valid, evt_valid2;
    logic       evt_note_on, evt_note_on2;
    logic [3:0] evt_channel, evt_channel2;
    logic [6:0] evt_key, evt_key2;
    logic [6:0] evt_velocity, evt_velocity2;
    logic [7:0] drop_count, drop_count2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    midi_event_parser dut (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_note_on(evt_note_on),
        .evt_channel(evt_channel), .evt_key(evt_key), .evt_velocity(evt_velocity),
        .drop_count(drop_count)
    );

    midi_event_parser #(
        .CHANNEL_MASK(16'h0001), .FIFO_DEPTH(4), .NOTE_OFF_EN(1'b0)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid2), .din(din2),
        .evt_valid(evt_valid2), .evt_ready(evt_ready2), .evt_note_on(evt_note_on2),
        .evt_channel(evt_channel2), .evt_key(evt_key2), .evt_velocity(evt_velocity2),
        .drop_count(drop_count2)
    );

    typedef struct packed {
        logic [63:0]       bs;
        logic [3:0]        n;
        logic [3:0]        ne;
        midi_event_t [3:0] ex;
    } vec_t;

    vec_t vecs [8];

    function automatic midi_event_t ev(input logic on, input logic [3:0] ch,
                                       input logic [6:0] k, input logic [6:0] v);
        midi_event_t e;
        e.note_on  = on;
        e.channel  = ch;
        e.key      = k;
        e.velocity = v;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input bit sel, input logic [7:0] b);
        if (sel) begin din2 = b; din_valid2 = 1'b1; end
        else     begin din  = b; din_valid  = 1'b1; end
        @(posedge clk);
        #1;
        din_valid  = 1'b0;
        din_valid2 = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic pop_check(input string name, input midi_event_t exp);
        check({name, "_vld"}, 32'(evt_valid), 32'd1);
        check(name, 32'({evt_note_on, evt_channel, evt_key, evt_velocity}), 32'(exp));
        evt_ready = 1'b1;
        @(posedge clk);
        #1;
        evt_ready = 1'b0;
    endtask

    task automatic pop_check2(input string name, input midi_event_t exp);
        check({name, "_vld"}, 32'(evt_valid2), 32'd1);
        check(name, 32'({evt_note_on2, evt_channel2, evt_key2, evt_velocity2}), 32'(exp));
        evt_ready2 = 1'b1;
        @(posedge clk);
        #1;
        evt_ready2 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; din_valid = 1'b0; din_valid2 = 1'b0;
        din = 8'h00; din2 = 8'h00; evt_ready = 1'b0; evt_ready2 = 1'b0;

        for (int i = 0; i < 8; i++) vecs[i] = '0;
        vecs[0].bs = 64'h9924640000000000; vecs[0].n = 3; vecs[0].ne = 1;
        vecs[0].ex[0] = ev(1'b1, 4'd9, 7'h24, 7'h64);
        vecs[1].bs = 64'h9924642650240000; vecs[1].n = 7; vecs[1].ne = 3;
        vecs[1].ex[0] = ev(1'b1, 4'd9, 7'h24, 7'h64);
        vecs[1].ex[1] = ev(1'b1, 4'd9, 7'h26, 7'h50);
        vecs[1].ex[2] = ev(1'b0, 4'd9, 7'h24, 7'h00);
        vecs[2].bs = 64'h9924F86400000000; vecs[2].n = 4; vecs[2].ne = 1;
        vecs[2].ex[0] = ev(1'b1, 4'd9, 7'h24, 7'h64);
        vecs[3].bs = 64'h99F0246400000000; vecs[3].n = 4; vecs[3].ne = 0;
        vecs[4].bs = 64'h9024640000000000; vecs[4].n = 3; vecs[4].ne = 0;
        vecs[5].bs = 64'hB9077F2464000000; vecs[5].n = 5; vecs[5].ne = 0;
        vecs[6].bs = 64'h8930550000000000; vecs[6].n = 3; vecs[6].ne = 1;
        vecs[6].ex[0] = ev(1'b0, 4'd9, 7'h30, 7'h00);
        vecs[7].bs = 64'h9924959930400000; vecs[7].n = 6; vecs[7].ne = 1;
        vecs[7].ex[0] = ev(1'b1, 4'd9, 7'h30, 7'h40);

        #1;
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_fields", 32'({evt_note_on, evt_channel, evt_key, evt_velocity}), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_valid2", 32'(evt_valid2), 32'd0);
        rst_n = 1'b1;
        idle(1);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            for (int j = 0; j < int'(vecs[i].n); j++) send(1'b0, vecs[i].bs[63-8*j -: 8]);
            idle(3);
            for (int j = 0; j < int'(vecs[i].ne); j++)
                pop_check($sformatf("vec%0d_ev%0d", i, j), vecs[i].ex[j]);
            check($sformatf("vec%0d_empty", i), 32'(evt_valid), 32'd0);
        end

        // Latency: evt_valid low after edge E, high after E+1.
        do_reset();
        send(1'b0, 8'h99);
        send(1'b0, 8'h24);
        din = 8'h64; din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        check("lat_E", 32'(evt_valid), 32'd0);
        idle(1);
        check("lat_E1", 32'(evt_valid), 32'd1);
        pop_check("lat_ev", ev(1'b1, 4'd9, 7'h24, 7'h64));

        // Variant: channel 1 accepted, Note Off suppressed.
        do_reset();
        send(1'b1, 8'h90); send(1'b1, 8'h24); send(1'b1, 8'h64);
        send(1'b1, 8'h80); send(1'b1, 8'h24); send(1'b1, 8'h64);
        send(1'b1, 8'h90); send(1'b1, 8'h25); send(1'b1, 8'h00);
        idle(3);
        pop_check2("mask_ev", ev(1'b1, 4'd0, 7'h24, 7'h64));
        check("nooff_empty", 32'(evt_valid2), 32'd0);

        // Overflow: ten events into a depth-4 FIFO with the consumer stalled.
        do_reset();
        send(1'b1, 8'h90);
        for (int k = 0; k < 10; k++) begin
            send(1'b1, 8'(8'h20 + k));
            send(1'b1, 8'h40);
        end
        idle(3);
        check("ovf_drop", 32'(drop_count2), 32'd6);
        for (int k = 0; k < 4; k++)
            pop_check2($sformatf("ovf_ev%0d", k), ev(1'b1, 4'd0, 7'(7'h20 + k), 7'h40));
        check("ovf_empty", 32'(evt_valid2), 32'd0);
        check("ovf_drop_hold", 32'(drop_count2), 32'd6);

        // Asynchronous reset mid-message with a buffered event and nonzero drop count.
        send(1'b0, 8'h99); send(1'b0, 8'h24); send(1'b0, 8'h64); send(1'b0, 8'h26);
        idle(2);
        check("pre_rst_valid", 32'(evt_valid), 32'd1);
        rst_n = 1'b0;
        #2;
        check("arst_valid", 32'(evt_valid), 32'd0);
        check("arst_drop2", 32'(drop_count2), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(1'b0, 8'h64);
        idle(3);
        check("post_rst_orphan", 32'(evt_valid), 32'd0);
        send(1'b0, 8'h99); send(1'b0, 8'h30); send(1'b0, 8'h40);
        idle(3);
        pop_check("post_rst_ev", ev(1'b1, 4'd9, 7'h30, 7'h40));
        check("post_rst_empty", 32'(evt_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
